// File: rtl/apb_mas_arb_ctrl.sv
// APB master controller: round-robin sharing of one APB master port between NUM_REQ requesters.
// Optional macro APB_ARB_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES and then errors the transfer.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STROB_WIDTH
`define APB_STROB_WIDTH 4
`endif

module apb_mas_arb_ctrl #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
  parameter int STRB_WIDTH     = `APB_STROB_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  input  logic [NUM_REQ*3-1:0]             req_prot,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_slverr,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTROB,
  output logic [2:0]                       PPROT,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          gnt_found;
  logic          timed_out;
  logic          done;
  logic          arb_point;

  assign done      = (state == ACCESS) && (PREADY || timed_out);
  assign arb_point = (state == IDLE) || done;

  // Search upward from the last grantee so the most recently served requester has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign req_ready = (arb_point && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] acc_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_cnt <= '0;
    end else if (state == SETUP) begin
      acc_cnt <= '0;
    end else if ((state == ACCESS) && !done) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // A PREADY in the limit cycle wins, so the timeout only fires while PREADY is low.
  assign timed_out = (state == ACCESS) && !PREADY && (acc_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NUM_REQ - 1);
      owner      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTROB     <= '0;
      PPROT      <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      if (done) begin
        rsp_valid  <= NUM_REQ'(1) << owner;
        rsp_slverr <= timed_out ? 1'b1 : PSLVERR;
        rsp_rdata  <= (PWRITE || timed_out) ? '0 : PRDATA;
      end

      case (state)
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        IDLE, ACCESS: begin
          if (arb_point) begin
            if (gnt_found) begin
              state   <= SETUP;
              rr_ptr  <= gnt_idx;
              owner   <= gnt_idx;
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PWRITE  <= req_write[gnt_idx];
              PADDR   <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
              PWDATA  <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
              PSTROB  <= req_write[gnt_idx] ? req_strb[gnt_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
              PPROT   <= req_prot[gnt_idx*3 +: 3];
            end else begin
              state   <= IDLE;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mas_arb_ctrl.sv
// Self-checking bench for apb_mas_arb_ctrl: directed protocol steps plus randomized traffic
// against a round-robin transaction model; APB_ARB_TIMEOUT_EN adds a timeout step.
module tb_apb_mas_arb_ctrl;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*SW-1:0] req_strb;
  logic [NR*3-1:0]  req_prot;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_slverr;
  logic             PSEL, PENABLE, PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA, PRDATA;
  logic [SW-1:0]    PSTROB;
  logic [2:0]       PPROT;
  logic             PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: pending requests, their fields, and the last grantee.
  logic          pend   [NR];
  logic          fWrite [NR];
  logic [AW-1:0] fAddr  [NR];
  logic [DW-1:0] fData  [NR];
  logic [SW-1:0] fStrb  [NR];
  logic [2:0]    fProt  [NR];
  int            modelPtr;

  int            g, cnt, waits, rspIdx;
  logic          rspDue;
  logic [DW-1:0] rspData;
  logic          rspErr;

  always #5 clk = ~clk;

  apb_mas_arb_ctrl #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTROB(PSTROB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = pend[i];
      req_write[i]            = fWrite[i];
      req_addr[i*AW +: AW]    = fAddr[i];
      req_wdata[i*DW +: DW]   = fData[i];
      req_strb[i*SW +: SW]    = fStrb[i];
      req_prot[i*3 +: 3]      = fProt[i];
    end
  endtask

  task automatic setReq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p);
    pend[i] = 1'b1; fWrite[i] = w; fAddr[i] = a; fData[i] = d; fStrb[i] = s; fProt[i] = p;
  endtask

  task automatic newRandReq(input int i);
    setReq(i, 1'($urandom_range(1, 0)), $urandom, $urandom, SW'($urandom), 3'($urandom));
  endtask

  function automatic int modelGrant();
    for (int k = 1; k <= NR; k++) begin
      if (pend[(modelPtr + k) % NR]) return (modelPtr + k) % NR;
    end
    return -1;
  endfunction

  // Present pending requests at an arbitration point, check the grant, then clock into SETUP.
  task automatic acceptCheck(input string tag, output int gnt);
    applyStimulus();
    #1;
    gnt = modelGrant();
    checkOutput(tag, req_ready, (gnt < 0) ? 64'd0 : (64'd1 << gnt));
    stepClk();
    if (gnt >= 0) begin
      pend[gnt] = 1'b0;
      modelPtr  = gnt;
      applyStimulus();
    end
  endtask

  task automatic checkSetup(input int i);
    checkOutput("setup_psel", PSEL, 1);
    checkOutput("setup_penable", PENABLE, 0);
    checkOutput("setup_paddr", PADDR, fAddr[i]);
    checkOutput("setup_pwrite", PWRITE, fWrite[i]);
    checkOutput("setup_pwdata", PWDATA, fData[i]);
    checkOutput("setup_pstrob", PSTROB, fWrite[i] ? fStrb[i] : 4'h0);
    checkOutput("setup_pprot", PPROT, fProt[i]);
  endtask

  task automatic checkRsp(input int i, input logic [DW-1:0] d, input logic e);
    checkOutput("rsp_valid", rsp_valid, 64'd1 << i);
    checkOutput("rsp_rdata", rsp_rdata, d);
    checkOutput("rsp_slverr", rsp_slverr, e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) setReq(i, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    modelPtr = NR - 1;
    applyStimulus();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    rspDue = 1'b0; rspIdx = 0; rspData = '0; rspErr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pstrob", PSTROB, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    rstn = 1'b1;
    stepClk();

    // Single zero-wait write from requester 0.
    PREADY = 1'b1;
    setReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    acceptCheck("wr_ready", g);
    checkSetup(g);
    stepClk();
    checkOutput("wr_access_penable", PENABLE, 1);
    checkOutput("wr_access_psel", PSEL, 1);
    stepClk();
    checkRsp(0, 32'h0, 1'b0);
    checkOutput("wr_idle_psel", PSEL, 0);

    // Read with 3 wait states; PRDATA/PSLVERR junk while PREADY low.
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hBAD0BAD0;
    setReq(1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b010);
    acceptCheck("rd_ready", g);
    checkSetup(g);
    stepClk();
    for (int w = 0; w < 4; w++) begin
      checkOutput("rd_wait_penable", PENABLE, 1);
      if (w == 3) begin
        PREADY = 1'b1; PRDATA = 32'h12345678; PSLVERR = 1'b0;
      end
      stepClk();
    end
    checkRsp(1, 32'h12345678, 1'b0);
    checkOutput("rd_done_penable", PENABLE, 0);

    // Contention: requesters 0 and 1 held valid for four back-to-back transfers.
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h55;
    setReq(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'h3, 3'b001);
    setReq(1, 1'b0, 32'h104, 32'h0B0B0B0B, 4'hC, 3'b100);
    for (int n = 0; n < 4; n++) begin
      acceptCheck("cont_ready", g);
      pend[g] = 1'b1;
      applyStimulus();
      if (n > 0) checkRsp(rspIdx, rspData, 1'b0);
      checkSetup(g);
      rspIdx  = g;
      rspData = fWrite[g] ? 32'h0 : PRDATA;
      stepClk();
      checkOutput("cont_access_penable", PENABLE, 1);
      if (n == 3) begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        applyStimulus();
      end
    end
    stepClk();
    checkRsp(rspIdx, rspData, 1'b0);
    checkOutput("cont_idle_psel", PSEL, 0);

    // Slave error on a write: slverr reported, rdata forced to zero.
    PSLVERR = 1'b1; PRDATA = 32'hCAFEF00D;
    setReq(2, 1'b1, 32'h30, 32'h01020304, 4'h5, 3'b011);
    acceptCheck("err_ready", g);
    checkSetup(g);
    stepClk();
    stepClk();
    checkRsp(2, 32'h0, 1'b1);
    PSLVERR = 1'b0;

    // Reset during an ACCESS wait state aborts the transfer and restores requester-0 priority.
    PREADY = 1'b0;
    setReq(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    acceptCheck("rstmid_ready", g);
    stepClk();
    stepClk();
    checkOutput("rstmid_penable_before", PENABLE, 1);
    rstn = 1'b0;
    #1;
    checkOutput("rstmid_psel", PSEL, 0);
    checkOutput("rstmid_penable", PENABLE, 0);
    checkOutput("rstmid_rsp_valid", rsp_valid, 0);
    modelPtr = NR - 1;
    stepClk();
    rstn = 1'b1;
    PREADY = 1'b1;
    stepClk();
    checkOutput("rstmid_no_rsp", rsp_valid, 0);
    setReq(0, 1'b1, 32'h44, 32'h11112222, 4'hF, 3'b000);
    setReq(1, 1'b1, 32'h48, 32'h33334444, 4'hF, 3'b000);
    setReq(2, 1'b1, 32'h4C, 32'h55556666, 4'hF, 3'b000);
    acceptCheck("rstmid_first_ready", g);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    applyStimulus();
    checkSetup(g);
    stepClk();
    stepClk();
    checkRsp(0, 32'h0, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
    // PREADY never arrives: the transfer is cut off after TO ACCESS cycles.
    PREADY = 1'b0;
    setReq(0, 1'b1, 32'h50, 32'h77778888, 4'hF, 3'b000);
    acceptCheck("to_ready", g);
    checkSetup(g);
    stepClk();
    cnt = 0;
    for (int c = 0; c < TO + 8 && PENABLE === 1'b1; c++) begin
      cnt++;
      stepClk();
    end
    checkOutput("to_cycles", cnt, TO);
    checkOutput("to_psel", PSEL, 0);
    checkRsp(0, 32'h0, 1'b1);
    PREADY = 1'b1;
`endif

    // Randomized traffic with random wait states, errors and idle gaps.
    rspDue = 1'b0;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) newRandReq(i);
      end
      if (!(pend[0] || pend[1] || pend[2])) newRandReq($urandom_range(NR - 1, 0));
      acceptCheck("rnd_ready", g);
      if (rspDue) checkRsp(rspIdx, rspData, rspErr);
      else checkOutput("rnd_no_rsp", rsp_valid, 0);
      checkSetup(g);
      checkOutput("rnd_setup_ready", req_ready, 0);
      PREADY = 1'b0;
      stepClk();
      waits = $urandom_range(3, 0);
      for (int w = 0; w < waits; w++) begin
        checkOutput("rnd_wait_penable", PENABLE, 1);
        PSLVERR = 1'($urandom_range(1, 0));
        PRDATA  = $urandom;
        stepClk();
      end
      checkOutput("rnd_access_penable", PENABLE, 1);
      PREADY  = 1'b1;
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(1, 0));
      rspIdx  = g;
      rspData = fWrite[g] ? 32'h0 : PRDATA;
      rspErr  = PSLVERR;
      rspDue  = 1'b1;
      if ($urandom_range(3, 0) == 0) begin
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        applyStimulus();
        stepClk();
        checkRsp(rspIdx, rspData, rspErr);
        checkOutput("rnd_idle_psel", PSEL, 0);
        rspDue = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    applyStimulus();
    stepClk();
    if (rspDue) checkRsp(rspIdx, rspData, rspErr);
    checkOutput("end_idle_psel", PSEL, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_mas_arb_ctrl.md
Name: apb_mas_arb_ctrl

Overview:
- APB master-side controller that shares one APB master port (PSEL/PENABLE/PADDR/PWDATA/PWRITE/PSTROB/PPROT out; PRDATA/PREADY/PSLVERR in) between NUM_REQ local requesters.
- Round-robin arbitration; sequences the APB IDLE -> SETUP -> ACCESS protocol; returns read data and error status to the granted requester.
- Sits between on-chip request sources and the APB bus that the master VIP interface monitors.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, `APB_ADDR_WIDTH, PADDR/req address width.
- DATA_WIDTH, `APB_DATA_WIDTH, PWDATA/PRDATA width.
- STRB_WIDTH, `APB_STROB_WIDTH, PSTROB width (DATA_WIDTH/8).
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_ready  out  NUM_REQ  one-hot accept; a transfer is accepted when req_valid[i] & req_ready[i].
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*STRB_WIDTH  packed write strobes.
- req_prot  in  NUM_REQ*3  packed protection attributes.
- rsp_valid  out  NUM_REQ  one-cycle one-hot completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; shared by all requesters; qualified by rsp_valid.
- rsp_slverr  out  1  error status for the completing transfer.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTROB  out  STRB_WIDTH  APB write strobes.
- PPROT  out  3  APB protection.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1  APB completion and error.

Behaviour:
- Reset (async assert): state = IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has highest priority next. Reset asserted mid-transfer aborts it with no rsp_valid.
- States:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0; always lasts exactly 1 cycle.
  - ACCESS: PSEL=1, PENABLE=1; held until PREADY=1.
- Arbitration point: any cycle with state==IDLE, or state==ACCESS && PREADY==1.
  - The grant is the first req_valid found searching upward from rr_ptr+1, with wrap-around.
  - req_ready is combinational, one-hot to the grantee, and 0 at all other times.
- On accept:
  - Capture write, addr, wdata, strb and prot into registers.
  - rr_ptr <= grantee.
  - Next state = SETUP.
  - With no valid request at an arbitration point, next state = IDLE.
- Back-to-back: ACCESS completion with a pending request goes directly to SETUP; PSEL stays 1 and PENABLE drops to 0.
- APB outputs are driven from registers and are stable from SETUP through the end of ACCESS. In IDLE, PADDR/PWRITE/PPROT hold their last values and PWDATA/PSTROB hold their last values.
- For reads, PSTROB is forced to all zeros.
- Completion (ACCESS && PREADY sampled 1), in the next cycle:
  - rsp_valid[grantee] = 1 for exactly one cycle.
  - rsp_slverr = PSLVERR.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - PRDATA and PSLVERR are ignored while PREADY=0.
- Latency: accept at cycle T -> SETUP at T+1 -> ACCESS at T+2. With zero-wait PREADY, rsp_valid is asserted at T+3.
- Requesters must hold their request fields stable while valid && !ready. Dropping valid before ready is legal and issues no transfer.
- Fairness: a requester that continuously asserts valid waits at most NUM_REQ-1 transfers.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter starts at 0 on entry to ACCESS.
  - If PREADY is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer is terminated: PSEL/PENABLE drop, the state moves to an arbitration point treated as completion, and rsp_valid pulses with rsp_slverr=1 and rsp_rdata=0.
  - A PREADY=1 arriving in the same cycle that the limit is reached takes precedence as a normal completion.
- Not defined: no counter logic; ACCESS waits for PREADY indefinitely.

Test Plan:
- Single write: req0, addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY held 1 -> SETUP at T+1, ACCESS at T+2, rsp_valid[0] at T+3, slverr=0.
- Read with 3 wait states: req1 read addr 0x20, PRDATA=0x12345678 at PREADY -> PENABLE high for 4 cycles, PSTROB=0, rsp_rdata=0x12345678.
- Contention: req0 and req1 both asserted continuously for 4 transfers -> grant order 0,1,0,1; back-to-back SETUP with no IDLE cycle between transfers.
- Error: PSLVERR=1 together with PREADY on a write -> rsp_slverr=1, rsp_rdata=0.
- Reset mid-ACCESS: rstn low during a wait state -> PSEL/PENABLE go to 0 immediately, no rsp_valid; after release, requester 0 wins first.
- Timeout (macro on, TIMEOUT_CYCLES=16): PREADY held 0 -> bus released after 16 ACCESS cycles, rsp_valid with slverr=1.
